uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, configurable frame format (data width, stop bits, runtime parity) and a valid/ready write interface. It supersedes the single-shot start/busy/done transmitter for use cases where a producer streams bytes without waiting for each frame to finish. It sits between on-chip producers (command engines, debug streamers) and the TX pin. It also serves as the stimulus source for receiver testbenches.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes
// and helpers for sizing the baud divisor and its counters.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } txState_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Clock cycles per bit; clamped to 1 so a fast line rate never yields a zero divisor.
    function automatic int calcDivisor(input int sCycle, input int baudRate);
        int d;
        d = sCycle / baudRate;
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Full and empty are decoded from the count; pointers simply wrap.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wrData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (level == (PTR_W + 1)'(DEPTH));
    assign empty  = (level == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; the count alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO, streaming frames back to back.
// Define UART_TX_PARITY_EN to build in the parity bit; otherwise the parity port is ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int SCYCLE   = 50000000,
    parameter int BAUDRATE = 115200,
    parameter int DWIDTH   = 8,
    parameter int DEPTH    = 16,
    parameter int STOPBITS = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DWIDTH-1:0]      txdata,
    input  logic                   txvalid,
    output logic                   txready,
    input  logic [1:0]             parity,
    output logic                   tx,
    output logic                   txbusy,
    output logic                   txdone,
    output logic [$clog2(DEPTH):0] level
);

    localparam int DIV    = calcDivisor(SCYCLE, BAUDRATE);
    localparam int BAUD_W = cntWidth(DIV);
    localparam int BIT_W  = cntWidth(DWIDTH);
    localparam int STOP_W = cntWidth(STOPBITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DWIDTH - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOPBITS - 1);

    txState_t          state;
    txState_t          stateNext;
    logic [BAUD_W-1:0] baudCnt;
    logic [BAUD_W-1:0] baudNext;
    logic [BIT_W-1:0]  bitIdx;
    logic [BIT_W-1:0]  bitNext;
    logic [STOP_W-1:0] stopCnt;
    logic [STOP_W-1:0] stopNext;
    logic [DWIDTH-1:0] dataLatch;
    logic [DWIDTH-1:0] fifoData;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              popReq;
    logic              baudLast;
    logic              txNext;
    logic              busyNext;
    logic              doneNext;

    uart_fifo #(
        .WIDTH(DWIDTH),
        .DEPTH(DEPTH)
    ) txFifo (
        .clock (clock),
        .reset (reset),
        .push  (txvalid),
        .wrData(txdata),
        .pop   (popReq),
        .rdData(fifoData),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .level (level)
    );

    assign txready  = !fifoFull;
    assign baudLast = (baudCnt == BAUD_LAST);

`ifdef UART_TX_PARITY_EN
    logic [1:0] parMode;
    logic       parityOn;
    logic       parityBit;

    // Mode is captured with the word so a mid-frame change cannot alter the frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            parMode <= PAR_NONE;
        end else if (popReq) begin
            parMode <= parity;
        end
    end

    assign parityOn  = (parMode == PAR_EVEN) || (parMode == PAR_ODD);
    assign parityBit = (^dataLatch) ^ (parMode == PAR_ODD);
`else
    logic unusedParity;
    assign unusedParity = ^parity;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            stopCnt   <= '0;
            dataLatch <= '0;
        end else begin
            state   <= stateNext;
            baudCnt <= baudNext;
            bitIdx  <= bitNext;
            stopCnt <= stopNext;
            if (popReq) begin
                dataLatch <= fifoData;
            end
        end
    end

    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitIdx;
        stopNext  = stopCnt;
        popReq    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    stateNext = ST_START;
                    baudNext  = '0;
                    popReq    = 1'b1;
                end
            end
            ST_START: begin
                if (baudLast) begin
                    stateNext = ST_DATA;
                    baudNext  = '0;
                    bitNext   = '0;
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (!baudLast) begin
                    baudNext = baudCnt + 1'b1;
                end else begin
                    baudNext = '0;
                    if (bitIdx != BIT_LAST) begin
                        bitNext = bitIdx + 1'b1;
                    end else begin
                        stateNext = ST_STOP;
                        stopNext  = '0;
`ifdef UART_TX_PARITY_EN
                        if (parityOn) begin
                            stateNext = ST_PARITY;
                        end
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baudLast) begin
                    stateNext = ST_STOP;
                    baudNext  = '0;
                    stopNext  = '0;
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
`endif
            // A queued word starts straight out of the last stop cycle, leaving no idle gap.
            ST_STOP: begin
                if (!baudLast) begin
                    baudNext = baudCnt + 1'b1;
                end else begin
                    baudNext = '0;
                    if (stopCnt != STOP_LAST) begin
                        stopNext = stopCnt + 1'b1;
                    end else if (!fifoEmpty) begin
                        stateNext = ST_START;
                        popReq    = 1'b1;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered line changes with the state.
    always_comb begin
        txNext = 1'b1;
        case (stateNext)
            ST_START:  txNext = 1'b0;
            ST_DATA:   txNext = dataLatch[bitNext];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txNext = parityBit;
`endif
            default:   txNext = 1'b1;
        endcase
        busyNext = (stateNext != ST_IDLE);
        doneNext = (stateNext == ST_STOP) && (baudNext == BAUD_LAST) && (stopNext == STOP_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx     <= 1'b1;
            txbusy <= 1'b0;
            txdone <= 1'b0;
        end else begin
            tx     <= txNext;
            txbusy <= busyNext;
            txdone <= doneNext;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a default-rate instance, a fast-divisor
// instance for back-to-back streaming, and a 7-bit/two-stop-bit instance.
module tb_uart_tx_fifo;

    localparam int DIV    = 434;
    localparam int DIVB   = 4;
    localparam int FRAMEB = 40;

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic [1:0] par;
        logic [15:0] expBits;
        int         expLen;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] txdataA, txdataB;
    logic [6:0] txdataC;
    logic       txvalidA, txvalidB, txvalidC;
    logic [1:0] parityA, parityB, parityC;
    logic       txreadyA, txreadyB, txreadyC;
    logic       txA, txB, txC;
    logic       txbusyA, txbusyB, txbusyC;
    logic       txdoneA, txdoneB, txdoneC;
    logic [4:0] levelA, levelB, levelC;

    int   compared = 0;
    int   mismatched = 0;
    vec_t vecs[5];

    always #5 clock = ~clock;

    uart_tx_fifo dutA (
        .clock(clock), .reset(reset), .txdata(txdataA), .txvalid(txvalidA),
        .txready(txreadyA), .parity(parityA), .tx(txA), .txbusy(txbusyA),
        .txdone(txdoneA), .level(levelA)
    );

    uart_tx_fifo #(.SCYCLE(40), .BAUDRATE(10)) dutB (
        .clock(clock), .reset(reset), .txdata(txdataB), .txvalid(txvalidB),
        .txready(txreadyB), .parity(parityB), .tx(txB), .txbusy(txbusyB),
        .txdone(txdoneB), .level(levelB)
    );

    uart_tx_fifo #(.DWIDTH(7), .STOPBITS(2)) dutC (
        .clock(clock), .reset(reset), .txdata(txdataC), .txvalid(txvalidC),
        .txready(txreadyC), .parity(parityC), .tx(txC), .txbusy(txbusyC),
        .txdone(txdoneC), .level(levelC)
    );

    function automatic logic getTx(input int sel);
        return (sel == 2) ? txC : txA;
    endfunction

    function automatic logic getBusy(input int sel);
        return (sel == 2) ? txbusyC : txbusyA;
    endfunction

    function automatic logic getDone(input int sel);
        return (sel == 2) ? txdoneC : txdoneA;
    endfunction

    function automatic logic [4:0] getLevel(input int sel);
        return (sel == 2) ? levelC : levelA;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Presents one word for a single edge; returns #1 after that edge.
    task automatic applyStimulus(input int sel, input logic [8:0] data, input logic [1:0] par);
        if (sel == 2) begin
            txdataC  = data[6:0];
            parityC  = par;
            txvalidC = 1'b1;
        end else begin
            txdataA  = data[7:0];
            parityA  = par;
            txvalidA = 1'b1;
        end
        @(posedge clock);
        #1;
        txvalidA = 1'b0;
        txvalidC = 1'b0;
    endtask

    task automatic checkFrame(input int idx, input vec_t v);
        int   doneCnt = 0;
        int   doneAt = -1;
        int   busyLow = 0;
        int   b;
        logic expBit;
        checkOutput($sformatf("v%0d_level_after_push", idx), 32'(getLevel(v.sel)), 32'd1);
        checkOutput($sformatf("v%0d_tx_idle_at_push", idx), 32'(getTx(v.sel)), 32'd1);
        for (int c = 1; c <= v.expLen + 1; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) begin
                checkOutput($sformatf("v%0d_start_tx", idx), 32'(getTx(v.sel)), 32'd0);
                checkOutput($sformatf("v%0d_start_busy", idx), 32'(getBusy(v.sel)), 32'd1);
                checkOutput($sformatf("v%0d_start_level", idx), 32'(getLevel(v.sel)), 32'd0);
            end
            if (c <= v.expLen && ((c - 1) % DIV) == DIV / 2) begin
                b = (c - 1) / DIV;
                expBit = (b == 0) ? 1'b0 : v.expBits[b - 1];
                checkOutput($sformatf("v%0d_bit%0d", idx, b), 32'(getTx(v.sel)), 32'(expBit));
            end
            if (getDone(v.sel)) begin
                doneCnt++;
                doneAt = c;
            end
            if (c <= v.expLen && !getBusy(v.sel)) begin
                busyLow++;
            end
        end
        checkOutput($sformatf("v%0d_done_count", idx), 32'(doneCnt), 32'd1);
        checkOutput($sformatf("v%0d_done_cycle", idx), 32'(doneAt), 32'(v.expLen));
        checkOutput($sformatf("v%0d_busy_gaps", idx), 32'(busyLow), 32'd0);
        checkOutput($sformatf("v%0d_busy_after", idx), 32'(getBusy(v.sel)), 32'd0);
        checkOutput($sformatf("v%0d_tx_after", idx), 32'(getTx(v.sel)), 32'd1);
    endtask

    initial begin
        int         accepted;
        int         doneCnt;
        int         badDone;
        int         lineErr;
        int         stray;
        int         off;
        int         f;
        int         j;
        int         e;
        logic [7:0] rxB [17];

        reset    = 1'b1;
        txdataA  = '0;
        txdataB  = '0;
        txdataC  = '0;
        txvalidA = 1'b0;
        txvalidB = 1'b0;
        txvalidC = 1'b0;
        parityA  = 2'b00;
        parityB  = 2'b00;
        parityC  = 2'b00;
        for (int k = 0; k < 17; k++) rxB[k] = '0;

        // Bits listed after the start bit, LSB first: data, optional parity, stop bits.
        vecs[0] = '{sel: 0, data: 9'h0AA, par: 2'b00, expBits: 16'h01AA, expLen: 4340};
`ifdef UART_TX_PARITY_EN
        vecs[1] = '{sel: 0, data: 9'h007, par: 2'b01, expBits: 16'h0307, expLen: 4774};
        vecs[2] = '{sel: 0, data: 9'h007, par: 2'b10, expBits: 16'h0207, expLen: 4774};
        vecs[4] = '{sel: 2, data: 9'h055, par: 2'b10, expBits: 16'h03D5, expLen: 4774};
`else
        vecs[1] = '{sel: 0, data: 9'h007, par: 2'b01, expBits: 16'h0107, expLen: 4340};
        vecs[2] = '{sel: 0, data: 9'h007, par: 2'b10, expBits: 16'h0107, expLen: 4340};
        vecs[4] = '{sel: 2, data: 9'h055, par: 2'b10, expBits: 16'h01D5, expLen: 4340};
`endif
        vecs[3] = '{sel: 0, data: 9'h03C, par: 2'b11, expBits: 16'h013C, expLen: 4340};

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_tx", 32'(txA), 32'd1);
        checkOutput("rst_busy", 32'(txbusyA), 32'd0);
        checkOutput("rst_done", 32'(txdoneA), 32'd0);
        checkOutput("rst_ready", 32'({txreadyA, txreadyB, txreadyC}), 32'd7);
        checkOutput("rst_level", 32'({levelA, levelB, levelC}), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("idle_tx", 32'({txA, txB, txC}), 32'd7);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].par);
            checkFrame(i, vecs[i]);
        end

        // Reset mid-frame: six words queued, the first is on the line, five wait.
        parityA = 2'b00;
        for (int c = 0; c < 6; c++) begin
            txdataA  = (c == 0) ? 8'hAA : 8'h33;
            txvalidA = 1'b1;
            @(posedge clock);
            #1;
        end
        txvalidA = 1'b0;
        repeat (1900 - 6) @(posedge clock);
        #1;
        checkOutput("midrst_level_before", 32'(levelA), 32'd5);
        checkOutput("midrst_bit3_before", 32'(txA), 32'd1);
        checkOutput("midrst_busy_before", 32'(txbusyA), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midrst_tx", 32'(txA), 32'd1);
        checkOutput("midrst_level", 32'(levelA), 32'd0);
        checkOutput("midrst_busy", 32'(txbusyA), 32'd0);
        checkOutput("midrst_done", 32'(txdoneA), 32'd0);
        checkOutput("midrst_ready", 32'(txreadyA), 32'd1);
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clock);
            #1;
            if (txA !== 1'b1 || txbusyA !== 1'b0 || txdoneA !== 1'b0) stray++;
        end
        checkOutput("midrst_no_frames", 32'(stray), 32'd0);

        // Twenty consecutive writes into instance B; edge numbers count from the first write.
        accepted = 0;
        doneCnt  = 0;
        badDone  = 0;
        lineErr  = 0;
        for (int c = 0; c <= 17 * FRAMEB + 4; c++) begin
            txvalidB = (c < 20);
            txdataB  = 8'(8'h10 + c);
            if (c < 20 && txreadyB) accepted++;
            @(posedge clock);
            #1;
            e = c + 1;
            if (e == 20) begin
                checkOutput("b2b_level_full", 32'(levelB), 32'd16);
                checkOutput("b2b_ready_low", 32'(txreadyB), 32'd0);
            end
            if (e >= 2) begin
                off = e - 2;
                f   = off / FRAMEB;
                j   = (off % FRAMEB) / DIVB;
                if (f < 17) begin
                    if ((off % FRAMEB) == 0 && txB !== 1'b0) lineErr++;
                    if ((off % DIVB) == 2 && j >= 1 && j <= 8) rxB[f][j - 1] = txB;
                    if ((off % DIVB) == 2 && j == 9 && txB !== 1'b1) lineErr++;
                    if (txbusyB !== 1'b1) lineErr++;
                end
            end
            if (txdoneB) begin
                doneCnt++;
                if (e < 41 || ((e - 41) % FRAMEB) != 0) badDone++;
            end
        end
        txvalidB = 1'b0;
        checkOutput("b2b_accepted", 32'(accepted), 32'd17);
        checkOutput("b2b_done_count", 32'(doneCnt), 32'd17);
        checkOutput("b2b_done_misplaced", 32'(badDone), 32'd0);
        checkOutput("b2b_line_errors", 32'(lineErr), 32'd0);
        checkOutput("b2b_busy_end", 32'(txbusyB), 32'd0);
        checkOutput("b2b_level_end", 32'(levelB), 32'd0);
        for (int k = 0; k < 17; k++) begin
            checkOutput($sformatf("b2b_word%0d", k), 32'(rxB[k]), 32'(8'(8'h10 + k)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
